// File: rtl/timer_share_pkg.sv
// timer_share_pkg: shared types and helpers for timer_share_arbiter
//   state_e   : arbiter FSM states (OFF, ON, GAP)
//   cnt_width : clog2-safe width of a down-counter reaching max(on, gap) - 1
package timer_share_pkg;
    typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, GAP = 2'd2} state_e;
    function automatic int cnt_width(input int on_c, input int gap_c);
        int m;
        m = (on_c > gap_c) ? on_c : gap_c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction
endpackage

// File: rtl/timer_share_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after i_ptr
//   i_req   [N]  request levels
//   i_ptr   [PW] highest-priority index
//   o_valid      any request set
//   o_gnt   [N]  one-hot winner (0 when none)
//   o_idx   [PW] winner index (0 when none)
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic          o_valid,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N]) begin
                o_valid = 1'b1;
                o_idx   = PW'((int'(i_ptr) + i) % N);
            end
        end
        o_gnt = o_valid ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter: round-robin share of one fixed-length pulse timer among NREQ requesters
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req  [N]   level requests, held until granted
//   gnt  [N]   one-hot owner while x is high
//   x          shared timed output, high for ON_CYCLES per grant
//   owner      index of current or most recent grantee
//   done       one-cycle pulse on the grant-expiry edge
// Optional: TIMER_SHARE_RETRIGGER_EN lets a rising edge on the owner's req reload the timer.
module timer_share_arbiter
    import timer_share_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ON_CYCLES  = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    x,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    done
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [OW-1:0]   r_ptr, r_owner;
    logic [NREQ-1:0] r_gnt;
    logic            r_x, r_done;
    logic [OW-1:0]   w_nptr, w_ptr, w_idx;
    logic [NREQ-1:0] w_gnt;
    logic            w_valid, w_retrig, w_expire, w_arb;

    assign w_nptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    // On the expiry edge (gap-less case) arbitration must already see the advanced pointer
    assign w_ptr  = (r_state == ON) ? w_nptr : r_ptr;

    rr_picker #(.N(NREQ), .PW(OW)) u_pick (
        .i_req  (req),
        .i_ptr  (w_ptr),
        .o_valid(w_valid),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

`ifdef TIMER_SHARE_RETRIGGER_EN
    logic [NREQ-1:0] r_req_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_req_q <= '0;
        else        r_req_q <= req;
    end
    assign w_retrig = (r_state == ON) && req[r_owner] && !r_req_q[r_owner];
`else
    assign w_retrig = 1'b0;
`endif

    // A retrigger landing on the expiry edge cancels the expiry
    assign w_expire = (r_state == ON) && (r_cnt == '0) && !w_retrig;
    assign w_arb    = (r_state == OFF) || (w_expire && GAP_CYCLES == 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_x     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_expire;
            if (w_expire) r_ptr <= w_nptr;
            if (w_arb && w_valid) begin
                r_state <= ON;
                r_gnt   <= w_gnt;
                r_owner <= w_idx;
                r_x     <= 1'b1;
                r_cnt   <= ON_LD;
            end else if (w_expire) begin
                r_state <= (GAP_CYCLES > 0) ? GAP : OFF;
                r_gnt   <= '0;
                r_x     <= 1'b0;
                r_cnt   <= GAP_LD;
            end else if (r_state == ON) begin
                r_cnt <= w_retrig ? ON_LD : r_cnt - 1'b1;
            end else if (r_state == GAP) begin
                if (r_cnt == '0) r_state <= OFF;
                else             r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    assign gnt   = r_gnt;
    assign x     = r_x;
    assign owner = r_owner;
    assign done  = r_done;
endmodule

// File: tb/tb_timer_share_arbiter.sv
// tb_timer_share_arbiter: directed vector bench for timer_share_arbiter (GAP=1 and GAP=0 instances)
module tb_timer_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n = 1'b0, rst1_n = 1'b0;
    logic [3:0] req0 = '0, req1 = '0, gnt0, gnt1;
    logic       x0, x1, done0, done1;
    logic [1:0] own0, own1;

    timer_share_arbiter #(.NREQ(4), .ON_CYCLES(3), .GAP_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst0_n), .req(req0), .gnt(gnt0), .x(x0), .owner(own0), .done(done0));
    timer_share_arbiter #(.NREQ(4), .ON_CYCLES(3), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst1_n), .req(req1), .gnt(gnt1), .x(x1), .owner(own1), .done(done1));

    typedef struct {
        string      nm;
        bit         dut;
        logic       rst_n;
        logic [3:0] req;
        logic [7:0] want;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0, n_bad = 0;

    function automatic void add(string nm, bit dut, logic r, logic [3:0] rq,
                                logic [3:0] g, logic xx, logic [1:0] o, logic d);
        vec_t v;
        v.nm = nm; v.dut = dut; v.rst_n = r; v.req = rq; v.want = {g, xx, o, d};
        tbl.push_back(v);
    endfunction

    function automatic logic [7:0] cur(bit dut);
        return dut ? {gnt1, x1, own1, done1} : {gnt0, x0, own0, done0};
    endfunction

    task automatic check(string nm, logic [7:0] got, logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b x=%b owner=%0d done=%b, want gnt=%b x=%b owner=%0d done=%b",
                     nm, got[7:4], got[3], got[2:1], got[0], want[7:4], want[3], want[2:1], want[0]);
        end
    endtask

    initial begin
        add("t1_rst", 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        for (int c = 0; c < 3; c++) add("t1_on", 0, 1, 4'b0100, 4'b0100, 1, 2, 0);
        add("t1_expire", 0, 1, 4'b0100, 4'b0000, 0, 2, 1);
        add("t1_gap",    0, 1, 4'b0100, 4'b0000, 0, 2, 0);
        for (int c = 0; c < 3; c++) add("t1_regrant", 0, 1, 4'b0100, 4'b0100, 1, 2, 0);
        add("t1_expire2", 0, 1, 4'b0100, 4'b0000, 0, 2, 1);

        add("t2_rst", 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) add("t2_on", 0, 1, 4'b1111, 4'(1 << (k % 4)), 1, 2'(k % 4), 0);
            add("t2_expire", 0, 1, 4'b1111, 4'b0000, 0, 2'(k % 4), 1);
            add("t2_gap",    0, 1, 4'b1111, 4'b0000, 0, 2'(k % 4), 0);
        end

        add("t3_rst",   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add("t3_pulse", 0, 1, 4'b0010, 4'b0010, 1, 1, 0);
        for (int c = 0; c < 2; c++) add("t3_on", 0, 1, 4'b0000, 4'b0010, 1, 1, 0);
        add("t3_expire", 0, 1, 4'b0000, 4'b0000, 0, 1, 1);
        for (int c = 0; c < 2; c++) add("t3_idle", 0, 1, 4'b0000, 4'b0000, 0, 1, 0);

        // GAP_CYCLES=0: back-to-back grants, x never drops
        add("t5_rst", 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        for (int c = 0; c < 3; c++) add("t5_on0", 1, 1, 4'b0011, 4'b0001, 1, 0, 0);
        add("t5_switch", 1, 1, 4'b0011, 4'b0010, 1, 1, 1);
        for (int c = 0; c < 2; c++) add("t5_on1", 1, 1, 4'b0011, 4'b0010, 1, 1, 0);
        add("t5_switch2", 1, 1, 4'b0011, 4'b0001, 1, 0, 1);

        // owner req 1 -> 0 -> 1: the rise is seen on the edge ending the 2nd ON cycle
        add("t6_rst",   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add("t6_grant", 0, 1, 4'b0001, 4'b0001, 1, 0, 0);
        add("t6_low",   0, 1, 4'b0000, 4'b0001, 1, 0, 0);
        add("t6_rise",  0, 1, 4'b0001, 4'b0001, 1, 0, 0);
`ifdef TIMER_SHARE_RETRIGGER_EN
        add("t6_ext1",   0, 1, 4'b0001, 4'b0001, 1, 0, 0);
        add("t6_ext2",   0, 1, 4'b0001, 4'b0001, 1, 0, 0);
        add("t6_expire", 0, 1, 4'b0000, 4'b0000, 0, 0, 1);
`else
        add("t6_expire", 0, 1, 4'b0000, 4'b0000, 0, 0, 1);
`endif
        add("t6_idle", 0, 1, 4'b0000, 4'b0000, 0, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].dut) begin
                rst1_n = tbl[i].rst_n; req1 = tbl[i].req;
            end else begin
                rst0_n = tbl[i].rst_n; req0 = tbl[i].req;
            end
            @(posedge clk);
            #1;
            check(tbl[i].nm, cur(tbl[i].dut), tbl[i].want);
        end

        // Async reset in the 2nd ON cycle; pointer is 1 here, so req=1001 would pick bit 3 without reset
        req0 = 4'b0100;
        @(posedge clk); #1;
        check("t4_on1", cur(0), {4'b0100, 1'b1, 2'd2, 1'b0});
        @(posedge clk); #1;
        check("t4_on2", cur(0), {4'b0100, 1'b1, 2'd2, 1'b0});
        #2 rst0_n = 1'b0;
        #1 check("t4_async", cur(0), 8'h00);
        req0 = 4'b1001;
        @(posedge clk); #1;
        check("t4_held", cur(0), 8'h00);
        rst0_n = 1'b1;
        @(posedge clk); #1;
        check("t4_ptr0", cur(0), {4'b0001, 1'b1, 2'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
